// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - grants the shared multicycle main memory to the D-cache or I-cache port
// D-cache requests win ties; the grant is held until its in-flight reads have all returned.
module mem_arbiter #(
   parameter int MEM_LAT = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        DMEM_RE,
   input  logic        DMEM_WE,
   input  logic [15:0] DMEM_MEM_addr,
   input  logic [15:0] MEM4_din,
   output logic        DMEM_rdata_valid,
   output logic [15:0] MEM4_dout,
   output logic        DMEM_WDONE,
   input  logic        IMEM_RE,
   input  logic [15:0] IMEM_MEM_addr,
   output logic        IMEM_rdata_valid,
   output logic [15:0] IMEM_dout,
   output logic        mem_enable,
   output logic        mem_wr,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_din,
   input  logic [15:0] mem_dout,
   input  logic        mem_data_valid
);

   typedef enum logic [1:0] {IDLE, D_RD, D_WR, I_RD} state_t;

   localparam logic [2:0] WCNT_LOAD = 3'(MEM_LAT - 1);

   state_t     state, state_nxt;
   logic [2:0] outstanding, outstanding_nxt;
   logic [2:0] wcnt, wcnt_nxt;
   logic       wr_wait, wr_wait_nxt;
   logic       rd_issue;
   logic       rd_ret;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         outstanding <= 3'd0;
         wcnt        <= 3'd0;
         wr_wait     <= 1'b0;
      end else begin
         state       <= state_nxt;
         outstanding <= outstanding_nxt;
         wcnt        <= wcnt_nxt;
         wr_wait     <= wr_wait_nxt;
      end
   end

   // A return with nothing outstanding is a leftover from before reset and is ignored.
   assign rd_ret = mem_data_valid && (outstanding != 3'd0);

   always_comb begin
      state_nxt        = state;
      wcnt_nxt         = wcnt;
      wr_wait_nxt      = wr_wait;
      rd_issue         = 1'b0;
      mem_enable       = 1'b0;
      mem_wr           = 1'b0;
      mem_addr         = 16'h0000;
      DMEM_rdata_valid = 1'b0;
      IMEM_rdata_valid = 1'b0;
      DMEM_WDONE       = 1'b0;
      case (state)
         IDLE: begin
            wr_wait_nxt = 1'b0;
            if (DMEM_WE)      state_nxt = D_WR;
            else if (DMEM_RE) state_nxt = D_RD;
            else if (IMEM_RE) state_nxt = I_RD;
         end
         D_RD: begin
            rd_issue         = DMEM_RE;
            mem_enable       = DMEM_RE;
            mem_addr         = DMEM_MEM_addr;
            DMEM_rdata_valid = rd_ret;
            if (!DMEM_RE && outstanding == 3'd0) state_nxt = IDLE;
         end
         I_RD: begin
            rd_issue         = IMEM_RE;
            mem_enable       = IMEM_RE;
            mem_addr         = IMEM_MEM_addr;
            IMEM_rdata_valid = rd_ret;
            if (!IMEM_RE && outstanding == 3'd0) state_nxt = IDLE;
         end
         D_WR: begin
            mem_addr = DMEM_MEM_addr;
            if (!wr_wait) begin
               mem_enable  = 1'b1;
               mem_wr      = 1'b1;
               wcnt_nxt    = WCNT_LOAD;
               wr_wait_nxt = 1'b1;
            end else if (wcnt == 3'd0) begin
               DMEM_WDONE  = 1'b1;
               wr_wait_nxt = 1'b0;
               state_nxt   = IDLE;
            end else begin
               wcnt_nxt = wcnt - 3'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
      outstanding_nxt = outstanding + {2'b00, rd_issue} - {2'b00, rd_ret};
   end

   assign mem_din   = MEM4_din;
   assign MEM4_dout = mem_dout;
   assign IMEM_dout = mem_dout;

endmodule
